// File: rtl/mem_pkg.sv
// Shared definitions for the data memory controller: funct3 access widths,
// FSM states and the byte-enable / load-extension helpers.
package mem_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic logic [3:0] byte_mask(input logic [2:0] typ, input logic [1:0] lane);
    logic [3:0] m;
    case (typ)
      MEM_B, MEM_BU: m = 4'b0001 << lane;
      MEM_H, MEM_HU: m = lane[1] ? 4'b1100 : 4'b0011;
      default:       m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] typ, input logic [1:0] lane,
                                           input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {lane, 3'b000};
    case (typ)
      MEM_B:   r = {{24{sh[7]}}, sh[7:0]};
      MEM_BU:  r = {24'd0, sh[7:0]};
      MEM_H:   r = {{16{sh[15]}}, sh[15:0]};
      MEM_HU:  r = {16'd0, sh[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store byte enables and replicated data,
// load extraction/extension, and natural-alignment check.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  typ,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_al,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  always_comb begin
    byte_en   = byte_mask(typ, lane);
    rdata_ext = load_ext(typ, lane, rword);
    wdata_al  = wdata;
    misalign  = 1'b0;
    case (typ)
      MEM_B, MEM_BU: wdata_al = {4{wdata[7:0]}};
      MEM_H, MEM_HU: begin
        wdata_al = {2{wdata[15:0]}};
        misalign = lane[0];
      end
      MEM_W:   misalign = (lane != 2'b00);
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory with valid/ready handshake and fixed access latency.
// Define MEM_STATS_EN to add load/store/error counters.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int    DEPTH     = 1024,
  parameter int    ADDR_W    = 32,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]       stat_loads,
  output logic [31:0]       stat_stores,
  output logic [31:0]       stat_errs
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t            state;
  logic [3:0]        cnt;
  logic              write_reg;
  logic [2:0]        type_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic              load_ok;
  logic [31:0]       rword_reg;
  logic [31:0]       mem [DEPTH];

  // In IDLE the live request drives the access path so LATENCY=0 can access on the accept edge.
  logic              acc_write;
  logic [2:0]        acc_type;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  assign acc_write = (state == IDLE) ? req_write : write_reg;
  assign acc_type  = (state == IDLE) ? req_type  : type_reg;
  assign acc_addr  = (state == IDLE) ? req_addr  : addr_reg;
  assign acc_wdata = (state == IDLE) ? req_wdata : wdata_reg;

  logic [3:0]  byte_en;
  logic [31:0] wdata_al;
  logic [31:0] rdata_ext;
  logic        misalign;

  mem_lane_align u_align (
    .typ       (acc_type),
    .lane      (acc_addr[1:0]),
    .wdata     (acc_wdata),
    .rword     (rword_reg),
    .byte_en   (byte_en),
    .wdata_al  (wdata_al),
    .rdata_ext (rdata_ext),
    .misalign  (misalign)
  );

  logic             illegal;
  logic             out_of_range;
  logic             acc_err;
  logic [IDX_W-1:0] idx;
  logic             enter_resp;
  assign illegal      = (acc_type == 3'b011) || (acc_type[2:1] == 2'b11) || (acc_write && acc_type[2]);
  assign out_of_range = (acc_addr[ADDR_W-1:IDX_W+2] != '0);
  assign acc_err      = illegal || out_of_range || misalign;
  assign idx          = acc_addr[IDX_W+1:2];
  assign enter_resp   = ((state == IDLE) && req_valid && (LATENCY == 0)) ||
                        ((state == WAIT) && (cnt == 4'd0));

  always_ff @(posedge clk) begin
    if (enter_resp) begin
      rword_reg <= mem[idx];
      if (acc_write && !acc_err) begin
        for (int i = 0; i < 4; i++) begin
          if (byte_en[i]) mem[idx][i*8 +: 8] <= wdata_al[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      load_ok    <= 1'b0;
      cnt        <= 4'd0;
      write_reg  <= 1'b0;
      type_reg   <= 3'd0;
      addr_reg   <= '0;
      wdata_reg  <= 32'd0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          write_reg <= req_write;
          type_reg  <= req_type;
          addr_reg  <= req_addr;
          wdata_reg <= req_wdata;
          req_ready <= 1'b0;
          if (LATENCY == 0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= acc_err;
            load_ok    <= !acc_err && !req_write;
          end else begin
            state <= WAIT;
            cnt   <= 4'(LATENCY - 1);
          end
        end
        WAIT: if (cnt == 4'd0) begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= acc_err;
          load_ok    <= !acc_err && !write_reg;
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP: if (resp_ready) begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          load_ok    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The read word is captured once on RESP entry, so the extended value holds stable.
  assign resp_rdata = load_ok ? rdata_ext : 32'd0;

`ifdef MEM_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_loads  <= 32'd0;
      stat_stores <= 32'd0;
      stat_errs   <= 32'd0;
    end else if (state == RESP && resp_ready) begin
      if (resp_err)       stat_errs   <= stat_errs + 32'd1;
      else if (write_reg) stat_stores <= stat_stores + 32'd1;
      else                stat_loads  <= stat_loads + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed testbench for data_mem_ctrl (LATENCY=2, DEPTH=1024).
module tb_data_mem_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_type = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
`ifdef MEM_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_errs;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH(1024), .ADDR_W(32), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_type   (req_type),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
`ifdef MEM_STATS_EN
    ,
    .stat_loads (stat_loads),
    .stat_stores(stat_stores),
    .stat_errs  (stat_errs)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request, wait for the response, and check its arrival cycle:
  // accept cycle is 0, resp_valid must be seen in cycle LAT+1.
  task automatic do_req(input string tag, input logic w, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_er);
    int cyc;
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_type = t; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, cyc, LAT + 1);
    check({tag, "_rdata"}, resp_rdata, exp_rd);
    check({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_er});
    $display("txn %s w=%0d t=%0d addr=%h wdata=%h -> rdata=%h err=%0d cyc=%0d",
             tag, w, t, a, d, resp_rdata, resp_err, cyc);
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, "_done"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // Basic word store/load
    do_req("sw10",  1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    do_req("lw10",  0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    // Byte / half access and extension
    do_req("sb11",  1, 3'b000, 32'h11, 32'h00000055, 32'h0, 0);
    do_req("lw10b", 0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 0);
    do_req("lb13",  0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 0);
    do_req("lbu13", 0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 0);
    do_req("lh12",  0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 0);
    do_req("lhu12", 0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 0);
    do_req("lh10",  0, 3'b001, 32'h10, 32'h0, 32'h000055EF, 0);
    do_req("sh12",  1, 3'b001, 32'h12, 32'hFFFF8001, 32'h0, 0);
    do_req("lw10c", 0, 3'b010, 32'h10, 32'h0, 32'h800155EF, 0);

    // Error cases leave memory untouched
    do_req("sw20",  1, 3'b010, 32'h20, 32'h11223344, 32'h0, 0);
    do_req("sw00",  1, 3'b010, 32'h0, 32'h01020304, 32'h0, 0);
    do_req("lw12",  0, 3'b010, 32'h12, 32'h0, 32'h0, 1);
    do_req("sh21",  1, 3'b001, 32'h21, 32'h0000AAAA, 32'h0, 1);
    do_req("t011",  0, 3'b011, 32'h20, 32'h0, 32'h0, 1);
    do_req("sbu20", 1, 3'b100, 32'h20, 32'h000000BB, 32'h0, 1);
    do_req("lwoor", 0, 3'b010, 32'h1000, 32'h0, 32'h0, 1);
    do_req("swoor", 1, 3'b010, 32'h1000, 32'h99999999, 32'h0, 1);
    do_req("lw20",  0, 3'b010, 32'h20, 32'h0, 32'h11223344, 0);
    do_req("lw00",  0, 3'b010, 32'h0, 32'h0, 32'h01020304, 0);

    // Back-pressure: hold resp_ready low, a new request must be ignored
    begin
      int cyc;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_type = 3'b010; req_addr = 32'h10;
      @(posedge clk); #1;
      req_valid = 1'b0;
      cyc = 1;
      while (!resp_valid && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("hold_lat", cyc, LAT + 1);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (i == 1) begin
          req_valid = 1'b1; req_write = 1'b1; req_type = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
        end else begin
          req_valid = 1'b0;
        end
        check("hold_valid", {31'd0, resp_valid}, 32'd1);
        check("hold_rdata", resp_rdata, 32'h800155EF);
        check("hold_ready", {31'd0, req_ready}, 32'd0);
        $display("txn hold cycle %0d valid=%0d rdata=%h req_ready=%0d", i, resp_valid, resp_rdata, req_ready);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("hold_done", {31'd0, resp_valid}, 32'd0);
      check("hold_idle", {31'd0, req_ready}, 32'd1);
    end
    do_req("lw10d", 0, 3'b010, 32'h10, 32'h0, 32'h800155EF, 0);

    // Asynchronous reset in the middle of a store's WAIT phase
    do_req("sw40",  1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_type = 3'b010; req_addr = 32'h40; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_wait_ready", {31'd0, req_ready}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("arst_ready", {31'd0, req_ready}, 32'd1);
    check("arst_valid", {31'd0, resp_valid}, 32'd0);
    check("arst_rdata", resp_rdata, 32'd0);
    $display("txn async reset mid-wait ready=%0d valid=%0d", req_ready, resp_valid);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    do_req("lw40",  0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 0);

`ifdef MEM_STATS_EN
    do_req("st_lw10", 0, 3'b010, 32'h10, 32'h0, 32'h800155EF, 0);
    do_req("st_lb13", 0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 0);
    do_req("st_sw50", 1, 3'b010, 32'h50, 32'h00000001, 32'h0, 0);
    do_req("st_sb51", 1, 3'b000, 32'h51, 32'h00000002, 32'h0, 0);
    do_req("st_lw52", 0, 3'b010, 32'h52, 32'h0, 32'h0, 1);
    check("stat_loads", stat_loads, 32'd3);
    check("stat_stores", stat_stores, 32'd2);
    check("stat_errs", stat_errs, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
